reg_dump: RTL

Register-file dump reader for the Mips core's debug read port. On a start pulse it walks `reg_out_id` across a configurable register range and samples `reg_out_data`. Each sampled (id, value) pair is emitted on a valid/ready stream. It sits beside `Mips`, driving the port the core already exposes, so benches and future host links can read architectural state without hierarchical references.

---
 rtl/reg_dump_pkg.sv | 14 +
 rtl/reg_dump_if.sv | 14 +
 rtl/reg_dump.sv | 102 ++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared widths and FSM state encoding for the register-file dump reader.
package reg_dump_pkg;

   localparam int REG_ID_W = 5;
   localparam int DATA_W   = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      SEND   = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/reg_dump_if.sv
// Valid/ready stream carrying one (register id, value) word per handshake.
interface reg_dump_if;
   import reg_dump_pkg::*;

   logic                out_valid;
   logic                out_ready;
   logic [REG_ID_W-1:0] out_id;
   logic [DATA_W-1:0]   out_data;
   logic                out_last;

   modport master (output out_valid, out_id, out_data, out_last, input out_ready);
   modport slave  (input out_valid, out_id, out_data, out_last, output out_ready);

endinterface

// File: rtl/reg_dump.sv
// Walks the Mips debug read port over [FIRST_REG..LAST_REG] and streams (id, value) words.
// Optional REG_DUMP_SKIP_ZERO_EN: registers sampling as zero are not emitted.
//
// state  | meaning
// IDLE   | waiting for start; index counter held at FIRST_REG
// SAMPLE | register reg_out_data / counter into the output word
// SEND   | out_valid high, word held until out_ready
// DONE   | one-cycle done pulse, then back to IDLE
module reg_dump
   import reg_dump_pkg::*;
#(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [REG_ID_W-1:0] reg_out_id,
   input  logic [DATA_W-1:0]   reg_out_data,
   reg_dump_if.master          strm
);

   localparam logic [REG_ID_W-1:0] FIRST_ID = REG_ID_W'(FIRST_REG);
   localparam logic [REG_ID_W-1:0] LAST_ID  = REG_ID_W'(LAST_REG);

   state_t              r_state;
   state_t              w_next;
   logic [REG_ID_W-1:0] r_cnt;
   logic [REG_ID_W-1:0] w_cnt_next;
   logic                w_capture;
   logic [REG_ID_W-1:0] r_out_id;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_last;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= FIRST_ID;
         r_out_id   <= '0;
         r_out_data <= '0;
         r_out_last <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_capture) begin
            r_out_id   <= r_cnt;
            r_out_data <= reg_out_data;
            r_out_last <= (r_cnt == LAST_ID);
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_capture  = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_next = FIRST_ID;
            if (start) w_next = SAMPLE;
         end
         SAMPLE: begin
`ifdef REG_DUMP_SKIP_ZERO_EN
            // zero registers are skipped without leaving SAMPLE
            if (reg_out_data == '0) begin
               if (r_cnt == LAST_ID) w_next = DONE;
               else                  w_cnt_next = r_cnt + REG_ID_W'(1);
            end else begin
               w_capture = 1'b1;
               w_next    = SEND;
            end
`else
            w_capture = 1'b1;
            w_next    = SEND;
`endif
         end
         SEND: begin
            if (strm.out_ready) begin
               if (r_cnt == LAST_ID) begin
                  w_next = DONE;
               end else begin
                  w_cnt_next = r_cnt + REG_ID_W'(1);
                  w_next     = SAMPLE;
               end
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign busy           = (r_state != IDLE);
   assign done           = (r_state == DONE);
   assign reg_out_id     = r_cnt;
   assign strm.out_valid = (r_state == SEND);
   assign strm.out_id    = r_out_id;
   assign strm.out_data  = r_out_data;
   assign strm.out_last  = r_out_last;

endmodule
